// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch (i) and load/store (d) requesters onto one memory port,
// tagging each request with a table index and steering responses back to their source.
module mem_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int NUM_TAGS   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] i_req_addr,
  input  logic [DATA_WIDTH-1:0] i_req_data,
  input  logic                  i_req_rw,
  input  logic [ID_WIDTH-1:0]   i_req_id,
  input  logic                  i_req_valid,
  output logic                  i_req_stall,
  output logic [DATA_WIDTH-1:0] i_rsp_data,
  output logic [ID_WIDTH-1:0]   i_rsp_id,
  output logic                  i_rsp_ready,
  input  logic [DATA_WIDTH-1:0] d_req_addr,
  input  logic [DATA_WIDTH-1:0] d_req_data,
  input  logic                  d_req_rw,
  input  logic [ID_WIDTH-1:0]   d_req_id,
  input  logic                  d_req_valid,
  output logic                  d_req_stall,
  output logic [DATA_WIDTH-1:0] d_rsp_data,
  output logic [ID_WIDTH-1:0]   d_rsp_id,
  output logic                  d_rsp_ready,
  output logic [DATA_WIDTH-1:0] mem_addr_out,
  output logic [DATA_WIDTH-1:0] mem_data_out,
  output logic                  mem_rw_out,
  output logic [ID_WIDTH-1:0]   mem_id_out,
  output logic                  mem_valid_out,
  input  logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic [ID_WIDTH-1:0]   mem_id_in,
  input  logic                  mem_ready_in,
  input  logic                  mem_stall_in,
  output logic                  tag_error
);

  localparam logic SRC_I = 1'b0;
  localparam logic SRC_D = 1'b1;

  logic [NUM_TAGS-1:0]   r_used;
  logic                  r_src [NUM_TAGS];
  logic [ID_WIDTH-1:0]   r_rid [NUM_TAGS];

  logic                  r_or_valid;
  logic [DATA_WIDTH-1:0] r_or_addr;
  logic [DATA_WIDTH-1:0] r_or_data;
  logic                  r_or_rw;
  logic [ID_WIDTH-1:0]   r_or_id;
  logic                  r_rr_last;
  logic                  r_tag_error;

  logic                  r_i_rsp_ready;
  logic [DATA_WIDTH-1:0] r_i_rsp_data;
  logic [ID_WIDTH-1:0]   r_i_rsp_id;
  logic                  r_d_rsp_ready;
  logic [DATA_WIDTH-1:0] r_d_rsp_data;
  logic [ID_WIDTH-1:0]   r_d_rsp_id;

  logic                  w_or_can_load;
  logic                  w_can_accept;
  logic                  w_grant_i;
  logic                  w_grant_d;
  logic                  w_accept;
  logic [ID_WIDTH-1:0]   w_alloc_idx;
  logic                  w_rsp_hit;
  logic                  w_rsp_src;
  logic [ID_WIDTH-1:0]   w_rsp_rid;

  // Allocation only looks at the current table, so an entry freed this cycle
  // becomes allocatable on the next one.
  always_comb begin
    w_or_can_load = !r_or_valid || !mem_stall_in;
    w_can_accept  = !reset && w_or_can_load && !(&r_used);
    w_grant_d     = d_req_valid && (!i_req_valid || r_rr_last == SRC_I);
    w_grant_i     = i_req_valid && !w_grant_d;
    w_accept      = w_can_accept && (w_grant_i || w_grant_d);
  end

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_alloc_idx = '0;
    for (int k = NUM_TAGS - 1; k >= 0; k--) begin
      if (!r_used[k]) w_alloc_idx = ID_WIDTH'(k);
    end
  end

  always_comb begin
    w_rsp_hit = 1'b0;
    w_rsp_src = SRC_I;
    w_rsp_rid = '0;
    for (int k = 0; k < NUM_TAGS; k++) begin
      if (mem_ready_in && mem_id_in == ID_WIDTH'(k) && r_used[k]) begin
        w_rsp_hit = 1'b1;
        w_rsp_src = r_src[k];
        w_rsp_rid = r_rid[k];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_used        <= '0;
      r_or_valid    <= 1'b0;
      r_or_addr     <= '0;
      r_or_data     <= '0;
      r_or_rw       <= 1'b0;
      r_or_id       <= '0;
      r_rr_last     <= SRC_D;
      r_tag_error   <= 1'b0;
      r_i_rsp_ready <= 1'b0;
      r_i_rsp_data  <= '0;
      r_i_rsp_id    <= '0;
      r_d_rsp_ready <= 1'b0;
      r_d_rsp_data  <= '0;
      r_d_rsp_id    <= '0;
    end else begin
      for (int k = 0; k < NUM_TAGS; k++) begin
        if (w_accept && w_alloc_idx == ID_WIDTH'(k)) r_used[k] <= 1'b1;
        else if (w_rsp_hit && mem_id_in == ID_WIDTH'(k)) r_used[k] <= 1'b0;
      end
      if (w_or_can_load) begin
        r_or_valid <= w_accept;
        if (w_accept) begin
          r_or_addr <= w_grant_d ? d_req_addr : i_req_addr;
          r_or_data <= w_grant_d ? d_req_data : i_req_data;
          r_or_rw   <= w_grant_d ? d_req_rw   : i_req_rw;
          r_or_id   <= w_alloc_idx;
        end
      end
      if (w_accept) r_rr_last <= w_grant_d;
      if (mem_ready_in && !w_rsp_hit) r_tag_error <= 1'b1;
      r_i_rsp_ready <= w_rsp_hit && w_rsp_src == SRC_I;
      r_d_rsp_ready <= w_rsp_hit && w_rsp_src == SRC_D;
      if (w_rsp_hit && w_rsp_src == SRC_I) begin
        r_i_rsp_data <= mem_data_in;
        r_i_rsp_id   <= w_rsp_rid;
      end
      if (w_rsp_hit && w_rsp_src == SRC_D) begin
        r_d_rsp_data <= mem_data_in;
        r_d_rsp_id   <= w_rsp_rid;
      end
    end
  end

  // NOTE: table payload is qualified by r_used, so it needs no reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_TAGS; k++) begin
      if (w_accept && w_alloc_idx == ID_WIDTH'(k)) begin
        r_src[k] <= w_grant_d;
        r_rid[k] <= w_grant_d ? d_req_id : i_req_id;
      end
    end
  end

  assign i_req_stall   = !(w_can_accept && w_grant_i);
  assign d_req_stall   = !(w_can_accept && w_grant_d);
  assign mem_valid_out = r_or_valid;
  assign mem_addr_out  = r_or_addr;
  assign mem_data_out  = r_or_data;
  assign mem_rw_out    = r_or_rw;
  assign mem_id_out    = r_or_id;
  assign tag_error     = r_tag_error;
  assign i_rsp_ready   = r_i_rsp_ready;
  assign i_rsp_data    = r_i_rsp_data;
  assign i_rsp_id      = r_i_rsp_id;
  assign d_rsp_ready   = r_d_rsp_ready;
  assign d_rsp_data    = r_d_rsp_data;
  assign d_rsp_id      = r_d_rsp_id;

endmodule
